// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch path: FSM state codes,
// PC mux select codes and the fetch address alignment helper.
package fetch_unit_pkg;

  localparam int unsigned PC_W  = 16;
  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ACCESS = 2'b01;
  localparam logic [1:0] ST_LOAD   = 2'b10;

  localparam logic [1:0] PC_SEL_INC   = 2'b00;
  localparam logic [1:0] PC_SEL_BUS   = 2'b01;
  localparam logic [1:0] PC_SEL_ADDER = 2'b10;

  // Instructions are 16-bit words; the byte bit of the PC is dropped.
  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] a);
    return a & ~PC_W'(1);
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: issues one memory read per start request,
// captures the word into ir, then strobes the PC mux to advance.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter logic [1:0]  INC_SEL = PC_SEL_INC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] mem_rdata,
  input  logic            mem_r,
  output logic            mem_en,
  output logic [PC_W-1:0] mem_addr,
  output logic            ld_pc,
  output logic [1:0]      pc_sel,
  output logic [PC_W-1:0] ir,
  output logic            ir_valid,
  output logic            busy,
  output logic            err
);

  logic [1:0]       state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [PC_W-1:0]  addr_q,     addr_d;
  logic [PC_W-1:0]  ir_q,       ir_d;
  logic             ir_valid_q, ir_valid_d;
  logic             mem_en_q,   mem_en_d;
  logic             ld_pc_q,    ld_pc_d;
  logic [1:0]       pc_sel_q,   pc_sel_d;
  logic             busy_q,     busy_d;
  logic             err_q,      err_d;

  // Next-state and output decode; outputs are registered from the next state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    err_d      = 1'b0;
    pc_sel_d   = INC_SEL;

    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          state_d    = ST_ACCESS;
          addr_d     = word_align(pc);
          ir_valid_d = 1'b0;
          cnt_d      = '0;
        end
      end
      ST_ACCESS: begin
        // Flush beats both a returning read and an expiring timeout.
        if (flush) begin
          state_d = ST_IDLE;
        end else if (mem_r) begin
          ir_d       = mem_rdata;
          ir_valid_d = 1'b1;
          state_d    = ST_LOAD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      // Fetch is committed once in LOAD, so flush does not cancel the PC update.
      ST_LOAD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    mem_en_d = (state_d == ST_ACCESS);
    ld_pc_d  = (state_d == ST_LOAD);
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      mem_en_q   <= 1'b0;
      ld_pc_q    <= 1'b0;
      pc_sel_q   <= INC_SEL;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      mem_en_q   <= mem_en_d;
      ld_pc_q    <= ld_pc_d;
      pc_sel_q   <= pc_sel_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign mem_en   = mem_en_q;
  assign mem_addr = addr_q;
  assign ld_pc    = ld_pc_q;
  assign pc_sel   = pc_sel_q;
  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected ld_pc/err events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] pc = 16'h0000;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_r = 1'b0;
  logic        mem_en, ld_pc, ir_valid, busy, err;
  logic [15:0] mem_addr, ir;
  logic [1:0]  pc_sel;

  always #5 clk = ~clk;

  fetch_unit #(.TIMEOUT(4), .INC_SEL(PC_SEL_INC)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .pc(pc),
    .mem_rdata(mem_rdata), .mem_r(mem_r), .mem_en(mem_en), .mem_addr(mem_addr),
    .ld_pc(ld_pc), .pc_sel(pc_sel), .ir(ir), .ir_valid(ir_valid),
    .busy(busy), .err(err)
  );

  typedef struct packed {
    logic        is_err;
    logic [15:0] addr;
    logic [15:0] ir;
    logic        ir_valid;
    logic [7:0]  busy_len;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         got_ev, exp_ev;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] acc_addr = 16'h0000;
  logic        in_acc = 1'b0;
  int          busy_len = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_load(input logic [15:0] a, input logic [15:0] d, input logic [7:0] len);
    exp_q.push_back('{is_err: 1'b0, addr: a, ir: d, ir_valid: 1'b1, busy_len: len});
  endtask

  // Monitor: tracks address stability through ACCESS and scores each ld_pc / err pulse.
  always @(negedge clk) begin
    if (busy === 1'b1) busy_len++;
    else busy_len = 0;

    if (mem_en === 1'b1) begin
      if (!in_acc) begin
        in_acc   = 1'b1;
        acc_addr = mem_addr;
      end else begin
        chk("mem_addr_hold", 32'(mem_addr), 32'(acc_addr));
      end
    end else begin
      in_acc = 1'b0;
    end

    if (ld_pc === 1'b1 || err === 1'b1) begin
      got_ev.is_err   = err;
      got_ev.addr     = acc_addr;
      got_ev.ir       = ir;
      got_ev.ir_valid = ir_valid;
      got_ev.busy_len = (ld_pc === 1'b1) ? 8'(busy_len) : 8'd0;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event: got ld_pc=%0b err=%0b, expected none", ld_pc, err);
      end else begin
        exp_ev = exp_q.pop_front();
        chk("ev_is_err",   32'(got_ev.is_err),   32'(exp_ev.is_err));
        chk("ev_addr",     32'(got_ev.addr),     32'(exp_ev.addr));
        chk("ev_ir",       32'(got_ev.ir),       32'(exp_ev.ir));
        chk("ev_ir_valid", 32'(got_ev.ir_valid), 32'(exp_ev.ir_valid));
        chk("ev_busy_len", 32'(got_ev.busy_len), 32'(exp_ev.busy_len));
        if (ld_pc === 1'b1) chk("ev_pc_sel", 32'(pc_sel), 32'(PC_SEL_INC));
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_mem_en",   32'(mem_en),   32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_ld_pc",    32'(ld_pc),    32'd0);
    chk("rst_ir",       32'(ir),       32'd0);
    chk("rst_ir_valid", 32'(ir_valid), 32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_err",      32'(err),      32'd0);
    chk("rst_pc_sel",   32'(pc_sel),   32'(PC_SEL_INC));
    rst = 1'b0;
    tick();

    // Basic fetch, read returns on third ACCESS cycle, pc moves mid-fetch
    expect_load(16'h3000, 16'h1234, 8'd4);
    pc = 16'h3000; start = 1'b1;
    tick();
    start = 1'b0; pc = 16'h7777;
    chk("acc_mem_en", 32'(mem_en), 32'd1);
    chk("acc_busy",   32'(busy),   32'd1);
    tick();
    tick();
    mem_r = 1'b1; mem_rdata = 16'h1234;
    tick();
    mem_r = 1'b0;
    chk("load_mem_en", 32'(mem_en), 32'd0);
    tick();
    chk("f1_busy",     32'(busy),     32'd0);
    chk("f1_ir",       32'(ir),       32'h1234);
    chk("f1_ir_valid", 32'(ir_valid), 32'd1);

    // Odd pc, immediate ready
    expect_load(16'h3000, 16'hABCD, 8'd2);
    pc = 16'h3001; start = 1'b1;
    tick();
    start = 1'b0; mem_r = 1'b1; mem_rdata = 16'hABCD;
    tick();
    mem_r = 1'b0;
    tick();
    chk("f2_busy", 32'(busy), 32'd0);

    // Timeout after 4 ACCESS cycles
    exp_q.push_back('{is_err: 1'b1, addr: 16'h2222, ir: 16'hABCD, ir_valid: 1'b0, busy_len: 8'd0});
    pc = 16'h2222; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("to_no_early_err", 32'(err),  32'd0);
    chk("to_still_busy",   32'(busy), 32'd1);
    tick();
    chk("to_err",  32'(err),  32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    tick();
    chk("to_err_pulse", 32'(err),      32'd0);
    chk("to_ir_valid",  32'(ir_valid), 32'd0);

    // Flush with simultaneous mem_r
    pc = 16'h4444; start = 1'b1;
    tick();
    start = 1'b0; flush = 1'b1; mem_r = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    flush = 1'b0; mem_r = 1'b0;
    chk("fl_busy",   32'(busy),   32'd0);
    chk("fl_mem_en", 32'(mem_en), 32'd0);
    chk("fl_ir",     32'(ir),     32'hABCD);
    chk("fl_err",    32'(err),    32'd0);
    tick();
    // start with flush in IDLE is not accepted
    start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("fl_idle_busy", 32'(busy), 32'd0);

    // Reset mid-ACCESS dominates start and mem_r
    pc = 16'h5000; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1; start = 1'b1; mem_r = 1'b1; mem_rdata = 16'h9999;
    tick();
    rst = 1'b0; start = 1'b0; mem_r = 1'b0;
    chk("mr_mem_en",   32'(mem_en),   32'd0);
    chk("mr_mem_addr", 32'(mem_addr), 32'd0);
    chk("mr_ir",       32'(ir),       32'd0);
    chk("mr_ir_valid", 32'(ir_valid), 32'd0);
    chk("mr_busy",     32'(busy),     32'd0);
    expect_load(16'h5002, 16'h5A5A, 8'd2);
    pc = 16'h5002; start = 1'b1;
    tick();
    start = 1'b0; mem_r = 1'b1; mem_rdata = 16'h5A5A;
    tick();
    mem_r = 1'b0;
    tick();

    // start held high: one fetch per IDLE entry
    expect_load(16'h6000, 16'h1111, 8'd2);
    expect_load(16'h6000, 16'h2222, 8'd2);
    pc = 16'h6000; start = 1'b1; mem_r = 1'b1; mem_rdata = 16'h1111;
    tick();
    tick();
    mem_rdata = 16'h2222;
    tick();
    chk("hold_idle_gap", 32'(busy), 32'd0);
    tick();
    start = 1'b0;
    tick();
    mem_r = 1'b0;
    tick();
    chk("hold_ir", 32'(ir), 32'h2222);

    // Flush during LOAD still issues ld_pc
    expect_load(16'h6100, 16'h3333, 8'd2);
    pc = 16'h6100; start = 1'b1;
    tick();
    start = 1'b0; mem_r = 1'b1; mem_rdata = 16'h3333;
    tick();
    mem_r = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("lf_busy", 32'(busy), 32'd0);

    repeat (3) tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
